dbg_mem_master: RTL and testbench
=================================

Name: dbg_mem_master

Overview:
- Debug-side bus initiator for the CPU data-memory bus.
- Accepts host commands to read words from, or fill, data memory. Before touching the bus it halts the CPU, waits a fixed settle time, then takes the bus via BUS_GRANT.
- Sits beside the CPU core; the top level muxes the memory address, data-out and read_wrn nets from this block whenever BUS_GRANT=1.
- Supports single accesses and auto-incrementing bursts with a response handshake.

Parameters:
- AW, 32: memory address width.
- LW, 8: burst length field width; words per command = CMD_LEN+1.
- HALT_SETTLE, 8: cycles between HALT_REQ rising and the first bus access (pipeline drain); legal range 1..255.
- RD_LAT, 0: extra cycles an address is held before MEM_ACCESS_DATA_IN_BUS is sampled; legal range 0..3.

Ports:
- CK_REF  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  block can accept a command.
- CMD_WRITE  in  1  1=fill (write), 0=read.
- CMD_ADDR  in  AW  start word address.
- CMD_LEN  in  LW  burst length minus one.
- CMD_WDATA  in  32  fill value written to every word of a write burst.
- RSP_VALID  out  1  response word available.
- RSP_READY  in  1  host accepts response.
- RSP_DATA  out  32  read data; for writes, the value written.
- RSP_LAST  out  1  marks the final response of a burst.
- HALT_REQ  out  1  drives CPU HALT.
- BUS_GRANT  out  1  memory bus mux select.
- MEM_ACCESS_ADDRESS_BUS  out  AW  access address.
- MEM_ACCESS_DATA_OUT_BUS  out  32  write data.
- MEM_ACCESS_READ_WRN  out  1  1=read, 0=write strobe.
- MEM_ACCESS_DATA_IN_BUS  in  32  read data (combinational from memory).

Behaviour:
- Reset (sync, RST=1 at a CK_REF edge): state IDLE.
  - Reset output values: CMD_READY=1, RSP_VALID=0, RSP_LAST=0, RSP_DATA=0, HALT_REQ=0, BUS_GRANT=0, address/data-out=0, READ_WRN=1.
  - Reset mid-operation aborts immediately: no write strobe in the cycle after reset, and the partial burst is discarded.
- States: IDLE, HALT_WAIT, ACCESS, RESP, RELEASE.
- IDLE: CMD_READY=1.
  - On CMD_VALID&CMD_READY: latch write/addr/len/wdata, set HALT_REQ=1, load settle counter = HALT_SETTLE-1, go to HALT_WAIT.
  - CMD_READY is 0 in every other state.
- HALT_WAIT: counter decrements each cycle; at 0, go to ACCESS with BUS_GRANT=1 registered into that same cycle.
  - Address/data-out drive from the latched values while BUS_GRANT=1, and are 0 otherwise.
- ACCESS: lasts RD_LAT+1 cycles.
  - Read: READ_WRN=1; at the final ACCESS edge, capture MEM_ACCESS_DATA_IN_BUS into RSP_DATA.
  - Write: READ_WRN=0 only in the final ACCESS cycle (exactly one strobe per word), and 1 otherwise; RSP_DATA=wdata.
  - Go to RESP.
- RESP: RSP_VALID=1, RSP_LAST=1 when remaining count==0. RSP_DATA is stable while RSP_VALID&!RSP_READY.
  - On RSP_READY: if remaining>0, decrement, address+1 (wraps modulo 2^AW, e.g. all-ones -> 0), go to ACCESS; bus stays granted and the CPU stays halted.
  - Else go to RELEASE.
- RELEASE: one cycle with BUS_GRANT=0, READ_WRN=1, HALT_REQ still 1. Next cycle: HALT_REQ=0 and state IDLE.
  - The grant always drops at least one cycle before the halt releases.
- Latency for a single read with RSP_READY held 1 (counted from the command handshake edge): HALT_SETTLE + RD_LAT + 1 cycles to RSP_VALID.
- CMD_VALID outside IDLE is ignored; commands are never queued.
- RSP_READY asserted while RSP_VALID=0 has no effect.
- CMD_LEN = 2^LW-1 gives a 2^LW-word burst with no counter overflow.

Test Plan:
- Read, mem[3]=0xDEADBEEF, len=0, RSP_READY=1, defaults:
  - HALT_REQ rises the cycle after the handshake; BUS_GRANT rises 8 cycles after HALT_REQ rises.
  - RSP_VALID arrives exactly 9 cycles after the handshake, with RSP_DATA=0xDEADBEEF and RSP_LAST=1.
  - BUS_GRANT falls 1 cycle before HALT_REQ.
- Fill addr=4, len=3, wdata=0x5A5A0001:
  - Exactly 4 READ_WRN=0 strobes, on addresses 4,5,6,7.
  - Memory words 4..7 = 0x5A5A0001; RSP_LAST asserted on the 4th response only.
- Read burst len=2 with RSP_READY low for 5 cycles on the 2nd word: RSP_DATA stays constant, address is held, and no extra accesses occur.
- Burst starting at addr 2^AW-1, len=1: the second access goes to address 0.
- RST asserted during the 2nd word of a 4-word fill:
  - Next cycle: READ_WRN=1, BUS_GRANT=0, HALT_REQ=0, CMD_READY=1.
  - Words 3 and 4 are unchanged.
- RD_LAT=2 single read: the address is held for 3 cycles and data is sampled on the 3rd; CMD_VALID pulsed mid-operation is not accepted (CMD_READY=0).

Source files
------------

// File: rtl/dbg_mem_master.sv
// Debug-side initiator for the CPU data-memory bus. A host command halts the
// CPU, waits for the pipeline to drain, takes the bus and performs a single
// word access or an auto-incrementing burst. Each word is answered on a
// valid/ready response channel.
`timescale 1ns/1ps
module dbg_mem_master #(
    parameter int AW          = 32,
    parameter int LW          = 8,
    parameter int HALT_SETTLE = 8,
    parameter int RD_LAT      = 0
) (
    input  logic          CK_REF,
    input  logic          RST,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_WRITE,
    input  logic [AW-1:0] CMD_ADDR,
    input  logic [LW-1:0] CMD_LEN,
    input  logic [31:0]   CMD_WDATA,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [31:0]   RSP_DATA,
    output logic          RSP_LAST,
    output logic          HALT_REQ,
    output logic          BUS_GRANT,
    output logic [AW-1:0] MEM_ACCESS_ADDRESS_BUS,
    output logic [31:0]   MEM_ACCESS_DATA_OUT_BUS,
    output logic          MEM_ACCESS_READ_WRN,
    input  logic [31:0]   MEM_ACCESS_DATA_IN_BUS
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        ACCESS    = 3'd2,
        RESP      = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_INIT = 8'(HALT_SETTLE - 1);
    localparam logic [1:0] ACC_INIT    = 2'(RD_LAT);

    state_t        state_r, state_s;
    logic          wr_r, wr_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [LW-1:0] rem_r, rem_s;
    logic [31:0]   wdata_r, wdata_s;
    logic [7:0]    settle_r, settle_s;
    logic [1:0]    acc_r, acc_s;
    logic [31:0]   rsp_data_r, rsp_data_s;

    logic          cmd_ready_r, cmd_ready_s;
    logic          rsp_valid_r, rsp_valid_s;
    logic          rsp_last_r, rsp_last_s;
    logic          halt_r, halt_s;
    logic          grant_r, grant_s;
    logic [AW-1:0] addr_out_r, addr_out_s;
    logic [31:0]   dout_r, dout_s;
    logic          read_wrn_r, read_wrn_s;

    // Next-state logic; all bus/handshake outputs are derived from the next state so they are registered.
    always_comb begin
        state_s    = state_r;
        wr_s       = wr_r;
        addr_s     = addr_r;
        rem_s      = rem_r;
        wdata_s    = wdata_r;
        settle_s   = settle_r;
        acc_s      = acc_r;
        rsp_data_s = rsp_data_r;

        case (state_r)
            IDLE: begin
                // CMD_READY is 1 throughout IDLE, so CMD_VALID alone is the handshake
                if (CMD_VALID) begin
                    state_s  = HALT_WAIT;
                    wr_s     = CMD_WRITE;
                    addr_s   = CMD_ADDR;
                    rem_s    = CMD_LEN;
                    wdata_s  = CMD_WDATA;
                    settle_s = SETTLE_INIT;
                end else begin
                    state_s = IDLE;
                end
            end
            HALT_WAIT: begin
                if (settle_r == 8'd0) begin
                    state_s = ACCESS;
                    acc_s   = ACC_INIT;
                end else begin
                    settle_s = settle_r - 8'd1;
                end
            end
            ACCESS: begin
                if (acc_r == 2'd0) begin
                    state_s    = RESP;
                    rsp_data_s = wr_r ? wdata_r : MEM_ACCESS_DATA_IN_BUS;
                end else begin
                    acc_s = acc_r - 2'd1;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    if (rem_r != {LW{1'b0}}) begin
                        state_s = ACCESS;
                        rem_s   = rem_r - LW'(1);
                        addr_s  = addr_r + AW'(1);
                        acc_s   = ACC_INIT;
                    end else begin
                        state_s = RELEASE;
                    end
                end else begin
                    state_s = RESP;
                end
            end
            RELEASE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        cmd_ready_s = (state_s == IDLE);
        halt_s      = (state_s != IDLE);
        grant_s     = (state_s == ACCESS) || (state_s == RESP);
        addr_out_s  = grant_s ? addr_s : {AW{1'b0}};
        dout_s      = grant_s ? wdata_s : 32'h0000_0000;
        // one write strobe per word: only in the last cycle of ACCESS
        read_wrn_s  = !(wr_s && (state_s == ACCESS) && (acc_s == 2'd0));
        rsp_valid_s = (state_s == RESP);
        rsp_last_s  = (state_s == RESP) && (rem_s == {LW{1'b0}});
    end

    // State and output registers with synchronous reset that aborts any operation.
    always_ff @(posedge CK_REF) begin
        if (RST) begin
            state_r     <= IDLE;
            wr_r        <= 1'b0;
            addr_r      <= {AW{1'b0}};
            rem_r       <= {LW{1'b0}};
            wdata_r     <= 32'h0000_0000;
            settle_r    <= 8'd0;
            acc_r       <= 2'd0;
            rsp_data_r  <= 32'h0000_0000;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            halt_r      <= 1'b0;
            grant_r     <= 1'b0;
            addr_out_r  <= {AW{1'b0}};
            dout_r      <= 32'h0000_0000;
            read_wrn_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            wr_r        <= wr_s;
            addr_r      <= addr_s;
            rem_r       <= rem_s;
            wdata_r     <= wdata_s;
            settle_r    <= settle_s;
            acc_r       <= acc_s;
            rsp_data_r  <= rsp_data_s;
            cmd_ready_r <= cmd_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_last_r  <= rsp_last_s;
            halt_r      <= halt_s;
            grant_r     <= grant_s;
            addr_out_r  <= addr_out_s;
            dout_r      <= dout_s;
            read_wrn_r  <= read_wrn_s;
        end
    end

    assign CMD_READY               = cmd_ready_r;
    assign RSP_VALID               = rsp_valid_r;
    assign RSP_DATA                = rsp_data_r;
    assign RSP_LAST                = rsp_last_r;
    assign HALT_REQ                = halt_r;
    assign BUS_GRANT               = grant_r;
    assign MEM_ACCESS_ADDRESS_BUS  = addr_out_r;
    assign MEM_ACCESS_DATA_OUT_BUS = dout_r;
    assign MEM_ACCESS_READ_WRN     = read_wrn_r;

endmodule

// File: tb/tb_dbg_mem_master.sv
// Bench for dbg_mem_master: directed commands, expected responses queued in a
// scoreboard and checked by a monitor; timing and bus checks inline.
`timescale 1ns/1ps
module tb_dbg_mem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed { logic [31:0] data; logic last; } exp_t;
    exp_t exp_q[$];
    exp_t exp2_q[$];
    logic [31:0] strobe_q[$];
    logic [31:0] rsp_addr_q[$];

    // DUT 1: default parameters
    logic rst, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_last;
    logic halt_req, bus_grant, mem_rwn;
    logic [31:0] cmd_addr, cmd_wdata, rsp_data, mem_addr, mem_dout, mem_din;
    logic [7:0]  cmd_len;

    // DUT 2: RD_LAT = 2
    logic cmd_valid2, cmd_ready2, cmd_write2, rsp_valid2, rsp_ready2, rsp_last2;
    logic halt_req2, bus_grant2, mem_rwn2;
    logic [31:0] cmd_addr2, cmd_wdata2, rsp_data2, mem_addr2, mem_dout2, mem_din2;
    logic [7:0]  cmd_len2;
    logic [7:0]  g2 = 8'd0;

    logic [31:0] mem [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;

    dbg_mem_master dut (
        .CK_REF(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_WRITE(cmd_write), .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .CMD_WDATA(cmd_wdata),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_LAST(rsp_last),
        .HALT_REQ(halt_req), .BUS_GRANT(bus_grant), .MEM_ACCESS_ADDRESS_BUS(mem_addr),
        .MEM_ACCESS_DATA_OUT_BUS(mem_dout), .MEM_ACCESS_READ_WRN(mem_rwn),
        .MEM_ACCESS_DATA_IN_BUS(mem_din)
    );

    dbg_mem_master #(.RD_LAT(2)) dut2 (
        .CK_REF(clk), .RST(rst), .CMD_VALID(cmd_valid2), .CMD_READY(cmd_ready2),
        .CMD_WRITE(cmd_write2), .CMD_ADDR(cmd_addr2), .CMD_LEN(cmd_len2), .CMD_WDATA(cmd_wdata2),
        .RSP_VALID(rsp_valid2), .RSP_READY(rsp_ready2), .RSP_DATA(rsp_data2), .RSP_LAST(rsp_last2),
        .HALT_REQ(halt_req2), .BUS_GRANT(bus_grant2), .MEM_ACCESS_ADDRESS_BUS(mem_addr2),
        .MEM_ACCESS_DATA_OUT_BUS(mem_dout2), .MEM_ACCESS_READ_WRN(mem_rwn2),
        .MEM_ACCESS_DATA_IN_BUS(mem_din2)
    );

    // memory model for DUT 1: combinational read, write on strobe, preload port
    assign mem_din = mem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end else if (bus_grant && !mem_rwn) begin
            mem[mem_addr[3:0]] <= mem_dout;
            strobe_q.push_back(mem_addr);
        end
    end

    // DUT 2 read data tags which granted cycle it was sampled in
    assign mem_din2 = {16'hC0DE, 8'h00, g2};
    always @(posedge clk) begin
        if (bus_grant2) g2 <= g2 + 8'd1;
        else            g2 <= 8'd0;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // scoreboard monitors: compare each accepted response against the queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb1_unexpected: got %h expected none", rsp_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb1_data", rsp_data, e.data);
                chk("sb1_last", {31'd0, rsp_last}, {31'd0, e.last});
            end
        end
        if (!rst && rsp_valid2 && rsp_ready2) begin
            if (exp2_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb2_unexpected: got %h expected none", rsp_data2);
            end else begin
                e = exp2_q.pop_front();
                chk("sb2_data", rsp_data2, e.data);
                chk("sb2_last", {31'd0, rsp_last2}, {31'd0, e.last});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l, input logic [31:0] d);
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_wdata = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_to_idle(input int max);
        int c;
        c = 0;
        while (halt_req && c < max) begin
            if (rsp_valid) rsp_addr_q.push_back(mem_addr);
            tick();
            c++;
        end
        chk("run_to_idle_halt", {31'd0, halt_req}, 32'd0);
    endtask

    initial begin
        int t_gr, t_v, t_gf, t_hf, base, k, held, ok;
        logic [31:0] hold_d, hold_a;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
        cmd_wdata = 32'd0; rsp_ready = 1'b1;
        cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_addr2 = 32'd0; cmd_len2 = 8'd0;
        cmd_wdata2 = 32'd0; rsp_ready2 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_last",  {31'd0, rsp_last},  32'd0);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        chk("rst_halt",      {31'd0, halt_req},  32'd0);
        chk("rst_grant",     {31'd0, bus_grant}, 32'd0);
        chk("rst_addr",      mem_addr, 32'd0);
        chk("rst_dout",      mem_dout, 32'd0);
        chk("rst_rwn",       {31'd0, mem_rwn},   32'd1);

        preload(4'd3, 32'hDEAD_BEEF);
        for (int i = 4; i < 8; i++) preload(4'(i), 32'h0000_0000);
        preload(4'd8,  32'hA000_0008);
        preload(4'd9,  32'hA000_0009);
        preload(4'd10, 32'hA000_000A);
        preload(4'd15, 32'hF000_000F);
        preload(4'd0,  32'h0000_0B0B);

        // single read: timing of halt, grant, response and release
        exp_q.push_back('{data: 32'hDEAD_BEEF, last: 1'b1});
        issue(1'b0, 32'd3, 8'd0, 32'd0);
        chk("t1_halt_rise", {31'd0, halt_req}, 32'd1);
        chk("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        t_gr = -1; t_v = -1; t_gf = -1; t_hf = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus_grant && t_gr < 0) t_gr = n;
            if (rsp_valid && t_v < 0) t_v = n;
            if (t_gr >= 0 && !bus_grant && t_gf < 0) t_gf = n;
            if (!halt_req) begin t_hf = n; break; end
        end
        chk("t1_grant_rise", 32'(t_gr), 32'd8);
        chk("t1_rsp_valid_lat", 32'(t_v), 32'd9);
        chk("t1_grant_fall", 32'(t_gf), 32'd10);
        chk("t1_halt_fall", 32'(t_hf), 32'd11);
        chk("t1_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // 4-word fill at address 4
        base = strobe_q.size();
        for (int i = 0; i < 4; i++) exp_q.push_back('{data: 32'h5A5A_0001, last: (i == 3)});
        issue(1'b1, 32'd4, 8'd3, 32'h5A5A_0001);
        run_to_idle(200);
        chk("t2_strobe_count", 32'(strobe_q.size() - base), 32'd4);
        if (strobe_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) chk("t2_strobe_addr", strobe_q[base + i], 32'(4 + i));
        end
        for (int i = 4; i < 8; i++) chk("t2_mem_word", mem[i], 32'h5A5A_0001);

        // 3-word read with a 5-cycle stall on word 2
        base = strobe_q.size();
        exp_q.push_back('{data: 32'hA000_0008, last: 1'b0});
        exp_q.push_back('{data: 32'hA000_0009, last: 1'b0});
        exp_q.push_back('{data: 32'hA000_000A, last: 1'b1});
        issue(1'b0, 32'd8, 8'd2, 32'd0);
        k = 0;
        while (!rsp_valid && k < 50) begin tick(); k++; end
        tick();
        rsp_ready = 1'b0;
        k = 0;
        while (!rsp_valid && k < 50) begin tick(); k++; end
        hold_d = rsp_data; hold_a = mem_addr; ok = 1;
        repeat (5) begin
            tick();
            if (rsp_data !== hold_d || mem_addr !== hold_a || !rsp_valid) ok = 0;
        end
        chk("t3_stall_stable", 32'(ok), 32'd1);
        chk("t3_stall_addr", hold_a, 32'd9);
        chk("t3_stall_data", hold_d, 32'hA000_0009);
        rsp_ready = 1'b1;
        run_to_idle(200);
        chk("t3_no_strobes", 32'(strobe_q.size() - base), 32'd0);

        // burst wrapping from the top address to 0
        base = rsp_addr_q.size();
        exp_q.push_back('{data: 32'hF000_000F, last: 1'b0});
        exp_q.push_back('{data: 32'h0000_0B0B, last: 1'b1});
        issue(1'b0, 32'hFFFF_FFFF, 8'd1, 32'd0);
        run_to_idle(200);
        chk("t4_rsp_count", 32'(rsp_addr_q.size() - base), 32'd2);
        if (rsp_addr_q.size() >= base + 2) begin
            chk("t4_first_addr", rsp_addr_q[base], 32'hFFFF_FFFF);
            chk("t4_wrap_addr", rsp_addr_q[base + 1], 32'd0);
        end

        // reset during word 2 of a 4-word fill
        for (int i = 12; i < 16; i++) preload(4'(i), 32'hCCCC_0000 | 32'(i));
        exp_q.push_back('{data: 32'h7777_0000, last: 1'b0});
        issue(1'b1, 32'd12, 8'd3, 32'h7777_0000);
        k = 0;
        while (!(bus_grant && mem_addr == 32'd13 && !rsp_valid) && k < 60) begin tick(); k++; end
        chk("t5_reach_word2", mem_addr, 32'd13);
        rst = 1'b1;
        tick();
        chk("t5_rwn", {31'd0, mem_rwn}, 32'd1);
        chk("t5_grant", {31'd0, bus_grant}, 32'd0);
        chk("t5_halt", {31'd0, halt_req}, 32'd0);
        chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("t5_word1", mem[12], 32'h7777_0000);
        chk("t5_word3", mem[14], 32'hCCCC_000E);
        chk("t5_word4", mem[15], 32'hCCCC_000F);

        // RD_LAT=2 single read, with a stray command pulse mid-operation
        exp2_q.push_back('{data: 32'hC0DE_0002, last: 1'b1});
        cmd_write2 = 1'b0; cmd_addr2 = 32'd5; cmd_len2 = 8'd0; cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        held = 0; t_v = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 4) begin
                cmd_valid2 = 1'b1; cmd_addr2 = 32'd9;
                chk("t6_cmd_ready_busy", {31'd0, cmd_ready2}, 32'd0);
            end
            if (n == 5) cmd_valid2 = 1'b0;
            tick();
            if (bus_grant2 && !rsp_valid2 && mem_addr2 == 32'd5) held++;
            if (rsp_valid2 && t_v < 0) t_v = n;
            if (!halt_req2) break;
        end
        chk("t6_addr_held", 32'(held), 32'd3);
        chk("t6_rsp_latency", 32'(t_v), 32'd11);
        ok = 1;
        repeat (6) begin
            tick();
            if (halt_req2 || !cmd_ready2) ok = 0;
        end
        chk("t6_no_queued_cmd", 32'(ok), 32'd1);

        chk("sb1_empty", 32'(exp_q.size()), 32'd0);
        chk("sb2_empty", 32'(exp2_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
